// File: rtl/fifo_burst_framer.sv
// Burst framer downstream of a FWFT FIFO: gathers up to MaxBurst words, then
// emits a header (count + flush flag) followed by the buffered payload.
module fifo_burst_framer #(
    parameter int DataWidth     = 32,
    parameter int MaxBurst      = 4,
    parameter int TimeoutCycles = 16,
    parameter int LenWidth      = $clog2(MaxBurst + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DataWidth-1:0] fifo_read_data,
    input  logic                 fifo_empty,
    output logic                 fifo_read_en,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DataWidth-1:0] out_data,
    output logic                 out_is_header,
    output logic                 out_last,
    output logic [15:0]          frame_count
);

    localparam int IdxW   = (MaxBurst > 1) ? $clog2(MaxBurst) : 1;
    localparam int TimerW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
    localparam logic [LenWidth-1:0] LastCount = LenWidth'(MaxBurst - 1);
    localparam logic [TimerW-1:0]   TimerLast = TimerW'(TimeoutCycles - 1);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        HEADER,
        PAYLOAD
    } state_t;

    state_t                state_q, state_d;
    logic [LenWidth-1:0]   count_q;
    logic [LenWidth-1:0]   index_q;
    logic [TimerW-1:0]     timer_q;
    logic                  flushed_q;
    logic [DataWidth-1:0]  burst_buf [MaxBurst];

    always_comb begin
        state_d       = state_q;
        fifo_read_en  = 1'b0;
        out_valid     = 1'b0;
        out_is_header = 1'b0;
        out_last      = 1'b0;
        out_data      = '0;
        case (state_q)
            IDLE: begin
                // Gated by rst so a held reset never pops (and loses) FIFO words.
                fifo_read_en = !fifo_empty && !rst;
                if (fifo_read_en) begin
                    state_d = (MaxBurst == 1) ? HEADER : COLLECT;
                end
            end
            COLLECT: begin
                fifo_read_en = !fifo_empty && !rst;
                if (fifo_read_en) begin
                    if (count_q == LastCount) begin
                        state_d = HEADER;
                    end
                end else if (timer_q == TimerLast) begin
                    state_d = HEADER;
                end
            end
            HEADER: begin
                out_valid                = 1'b1;
                out_is_header            = 1'b1;
                out_data[DataWidth-1]    = flushed_q;
                out_data[LenWidth-1:0]   = count_q;
                if (out_ready) begin
                    state_d = PAYLOAD;
                end
            end
            PAYLOAD: begin
                out_valid = 1'b1;
                out_data  = burst_buf[index_q[IdxW-1:0]];
                out_last  = (index_q == count_q - LenWidth'(1));
                if (out_ready && out_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            count_q     <= '0;
            index_q     <= '0;
            timer_q     <= '0;
            flushed_q   <= 1'b0;
            frame_count <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (fifo_read_en) begin
                        burst_buf[0] <= fifo_read_data;
                        count_q      <= LenWidth'(1);
                        timer_q      <= '0;
                        flushed_q    <= 1'b0;
                    end
                end
                COLLECT: begin
                    if (fifo_read_en) begin
                        burst_buf[count_q[IdxW-1:0]] <= fifo_read_data;
                        count_q   <= count_q + LenWidth'(1);
                        timer_q   <= '0;
                        flushed_q <= 1'b0;
                    end else if (timer_q == TimerLast) begin
                        // Timer saturates here; it is cleared on the next burst's first pop.
                        flushed_q <= 1'b1;
                    end else begin
                        timer_q <= timer_q + TimerW'(1);
                    end
                end
                HEADER: begin
                    if (out_ready) begin
                        index_q <= '0;
                    end
                end
                PAYLOAD: begin
                    if (out_ready) begin
                        if (out_last) begin
                            frame_count <= frame_count + 16'd1;
                        end else begin
                            index_q <= index_q + LenWidth'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_burst_framer.sv
// Directed bench for fifo_burst_framer with a small FWFT FIFO model feeding it.
module tb_fifo_burst_framer;

    logic        clk;
    logic        rst;
    logic [31:0] fifo_read_data;
    logic        fifo_empty;
    logic        fifo_read_en;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_is_header;
    logic        out_last;
    logic [15:0] frame_count;

    int n_checks = 0;
    int n_fail   = 0;

    // FIFO model: initial block pushes, clocked process pops.
    logic [31:0] mem [64];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    bit          underflow = 1'b0;

    assign fifo_empty     = (rd_ptr == wr_ptr);
    assign fifo_read_data = mem[rd_ptr[5:0]];

    always @(posedge clk) begin
        if (fifo_read_en === 1'b1 && fifo_empty) underflow <= 1'b1;
        if (fifo_read_en === 1'b1 && !fifo_empty) rd_ptr <= rd_ptr + 1;
    end

    fifo_burst_framer #(
        .DataWidth(32),
        .MaxBurst(4),
        .TimeoutCycles(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .fifo_read_data(fifo_read_data),
        .fifo_empty(fifo_empty),
        .fifo_read_en(fifo_read_en),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_is_header(out_is_header),
        .out_last(out_last),
        .frame_count(frame_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] cap_data [$];
    bit          cap_hdr  [$];
    bit          cap_last [$];
    int          cap_cyc  [$];
    bit [31:0]   rd_vec;

    task automatic push_word(input logic [31:0] v);
        mem[wr_ptr[5:0]] = v;
        wr_ptr = wr_ptr + 1;
    endtask

    // Called at a negedge; samples each cycle 1ns later, logs pops and handshakes.
    task automatic run_cycles(input int n, input bit rdy);
        cap_data.delete(); cap_hdr.delete(); cap_last.delete(); cap_cyc.delete();
        rd_vec = '0;
        for (int i = 0; i < n; i++) begin
            out_ready = rdy;
            #1;
            rd_vec[i] = (fifo_read_en === 1'b1);
            if (out_valid === 1'b1 && out_ready) begin
                cap_data.push_back(out_data);
                cap_hdr.push_back(out_is_header);
                cap_last.push_back(out_last);
                cap_cyc.push_back(i);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        out_ready = 1'b0;
        push_word(32'h55);
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if ({fifo_read_en, out_valid, out_data, frame_count} !== {2'b00, 32'h0, 16'h0}) begin
            n_fail++;
            $display("FAIL reset_outputs: rd_en=%b valid=%b data=%h fc=%0d, expected 0 0 00000000 0",
                     fifo_read_en, out_valid, out_data, frame_count);
        end
        wr_ptr = rd_ptr;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_empty_guard();
        int bad = 0;
        for (int i = 0; i < 100; i++) begin
            #1;
            if (fifo_read_en !== 1'b0 || out_valid !== 1'b0) bad++;
            @(negedge clk);
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL empty_guard: %0d cycles with rd_en/valid active, expected 0", bad);
        end
    endtask

    task automatic test_full_burst();
        logic [31:0] exp_d [5] = '{32'h4, 32'hA0, 32'hA1, 32'hA2, 32'hA3};
        push_word(32'hA0); push_word(32'hA1); push_word(32'hA2); push_word(32'hA3);
        run_cycles(12, 1'b1);
        n_checks++;
        if (rd_vec[11:0] !== 12'h00F) begin
            n_fail++;
            $display("FAIL full_rd_pattern: got %h expected 00f", rd_vec[11:0]);
        end
        n_checks++;
        if (cap_data.size() !== 5) begin
            n_fail++;
            $display("FAIL full_word_count: got %0d expected 5", cap_data.size());
        end else begin
            n_checks++;
            if (cap_cyc[0] !== 4) begin
                n_fail++;
                $display("FAIL full_header_latency: got cycle %0d expected 4", cap_cyc[0]);
            end
            for (int k = 0; k < 5; k++) begin
                n_checks++;
                if ({cap_hdr[k], cap_last[k], cap_data[k]} !== {k == 0, k == 4, exp_d[k]}) begin
                    n_fail++;
                    $display("FAIL full_word%0d: got hdr=%b last=%b data=%h expected hdr=%b last=%b data=%h",
                             k, cap_hdr[k], cap_last[k], cap_data[k], k == 0, k == 4, exp_d[k]);
                end
            end
        end
        n_checks++;
        if (frame_count !== 16'd1) begin
            n_fail++;
            $display("FAIL full_frame_count: got %0d expected 1", frame_count);
        end
    endtask

    task automatic test_timeout_flush();
        logic [31:0] exp_d [3] = '{32'h80000002, 32'h11, 32'h22};
        push_word(32'h11); push_word(32'h22);
        run_cycles(24, 1'b1);
        n_checks++;
        if (rd_vec[23:0] !== 24'h3) begin
            n_fail++;
            $display("FAIL timeout_rd_pattern: got %h expected 000003", rd_vec[23:0]);
        end
        n_checks++;
        if (cap_data.size() !== 3) begin
            n_fail++;
            $display("FAIL timeout_word_count: got %0d expected 3", cap_data.size());
        end else begin
            n_checks++;
            if (cap_cyc[0] !== 18) begin
                n_fail++;
                $display("FAIL timeout_header_latency: got cycle %0d expected 18", cap_cyc[0]);
            end
            for (int k = 0; k < 3; k++) begin
                n_checks++;
                if ({cap_hdr[k], cap_last[k], cap_data[k]} !== {k == 0, k == 2, exp_d[k]}) begin
                    n_fail++;
                    $display("FAIL timeout_word%0d: got hdr=%b last=%b data=%h expected hdr=%b last=%b data=%h",
                             k, cap_hdr[k], cap_last[k], cap_data[k], k == 0, k == 2, exp_d[k]);
                end
            end
        end
        n_checks++;
        if (frame_count !== 16'd2) begin
            n_fail++;
            $display("FAIL timeout_frame_count: got %0d expected 2", frame_count);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_d [5] = '{32'h4, 32'hC0, 32'hC1, 32'hC2, 32'hC3};
        logic [31:0] got [$];
        bit          got_last [$];
        push_word(32'hC0); push_word(32'hC1); push_word(32'hC2); push_word(32'hC3);
        for (int i = 0; i < 22; i++) begin
            out_ready = !((i >= 4 && i <= 8) || (i >= 12 && i <= 16));
            #1;
            if (i >= 4 && i <= 8) begin
                n_checks++;
                if ({out_valid, out_is_header, out_last, out_data} !== {3'b110, 32'h4}) begin
                    n_fail++;
                    $display("FAIL bp_header_hold c%0d: got v=%b h=%b l=%b d=%h expected 1 1 0 00000004",
                             i, out_valid, out_is_header, out_last, out_data);
                end
            end
            if (i >= 12 && i <= 16) begin
                n_checks++;
                if ({out_valid, out_is_header, out_last, out_data} !== {3'b100, 32'hC2}) begin
                    n_fail++;
                    $display("FAIL bp_payload_hold c%0d: got v=%b h=%b l=%b d=%h expected 1 0 0 000000c2",
                             i, out_valid, out_is_header, out_last, out_data);
                end
            end
            if (out_valid === 1'b1) begin
                n_checks++;
                if (fifo_read_en !== 1'b0) begin
                    n_fail++;
                    $display("FAIL bp_no_pop c%0d: rd_en=%b expected 0", i, fifo_read_en);
                end
                if (out_ready) begin
                    got.push_back(out_data);
                    got_last.push_back(out_last);
                end
            end
            @(negedge clk);
        end
        n_checks++;
        if (got.size() !== 5) begin
            n_fail++;
            $display("FAIL bp_word_count: got %0d expected 5", got.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                n_checks++;
                if ({got_last[k], got[k]} !== {k == 4, exp_d[k]}) begin
                    n_fail++;
                    $display("FAIL bp_word%0d: got last=%b data=%h expected last=%b data=%h",
                             k, got_last[k], got[k], k == 4, exp_d[k]);
                end
            end
        end
        n_checks++;
        if (frame_count !== 16'd3) begin
            n_fail++;
            $display("FAIL bp_frame_count: got %0d expected 3", frame_count);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] exp_d [5] = '{32'h4, 32'hB0, 32'hB1, 32'hB2, 32'hB3};
        push_word(32'hD0); push_word(32'hD1); push_word(32'hD2); push_word(32'hD3);
        run_cycles(7, 1'b1);
        n_checks++;
        if (cap_data.size() !== 3) begin
            n_fail++;
            $display("FAIL midrst_pre_count: got %0d handshakes expected 3", cap_data.size());
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++;
        if ({out_valid, frame_count} !== {1'b0, 16'h0}) begin
            n_fail++;
            $display("FAIL midrst_after_reset: got valid=%b fc=%0d expected 0 0", out_valid, frame_count);
        end
        @(negedge clk);
        push_word(32'hB0); push_word(32'hB1); push_word(32'hB2); push_word(32'hB3);
        run_cycles(12, 1'b1);
        n_checks++;
        if (rd_vec[11:0] !== 12'h00F) begin
            n_fail++;
            $display("FAIL midrst_rd_pattern: got %h expected 00f", rd_vec[11:0]);
        end
        n_checks++;
        if (cap_data.size() !== 5) begin
            n_fail++;
            $display("FAIL midrst_word_count: got %0d expected 5", cap_data.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                n_checks++;
                if ({cap_hdr[k], cap_last[k], cap_data[k]} !== {k == 0, k == 4, exp_d[k]}) begin
                    n_fail++;
                    $display("FAIL midrst_word%0d: got hdr=%b last=%b data=%h expected hdr=%b last=%b data=%h",
                             k, cap_hdr[k], cap_last[k], cap_data[k], k == 0, k == 4, exp_d[k]);
                end
            end
        end
        n_checks++;
        if (frame_count !== 16'd1) begin
            n_fail++;
            $display("FAIL midrst_frame_count: got %0d expected 1", frame_count);
        end
    endtask

    initial begin
        rst = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_empty_guard();
        test_full_burst();
        test_timeout_flush();
        test_backpressure();
        test_reset_mid_frame();
        n_checks++;
        if (underflow !== 1'b0) begin
            n_fail++;
            $display("FAIL no_underflow: pop seen while empty=%b expected 0", underflow);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_burst_framer.md
Name: fifo_burst_framer

Overview:
- Sits directly downstream of the team's synchronous FIFO.
- Drains the FIFO's first-word-fall-through read port into a local burst buffer of up to MaxBurst words.
- Emits each burst on a valid/ready output stream as one header word (word count plus flush flag), followed by the buffered payload words.
- A partial burst is flushed after TimeoutCycles consecutive cycles in which the FIFO is empty.

Parameters:
- DataWidth, 32, width of the FIFO data words and output words.
- MaxBurst, 4, maximum payload words per frame; must be >= 1.
- TimeoutCycles, 16, number of consecutive empty cycles during collection before a partial burst is flushed; must be >= 1.
- LenWidth, $clog2(MaxBurst+1), width of the count field in the header; must be < DataWidth.

Ports:
- clk, input, 1, single clock; all logic is on the rising edge.
- rst, input, 1, reset: synchronous and active-high.
- fifo_read_data, input, DataWidth, FIFO head word; valid whenever fifo_empty=0.
- fifo_empty, input, 1, FIFO empty flag.
- fifo_read_en, output, 1, pops the FIFO head at the current clock edge.
- out_valid, output, 1, output word valid.
- out_ready, input, 1, downstream accepts the output word.
- out_data, output, DataWidth, header or payload word.
- out_is_header, output, 1, current out_data is a header word.
- out_last, output, 1, current out_data is the final payload word of the frame.
- frame_count, output, 16, number of frames completed; wraps at 0xFFFF to 0.

Behaviour:
- Reset (synchronous, rst=1 at an edge):
  - state becomes IDLE; count, index and timer become 0; frame_count becomes 0; buffer contents are don't-care.
  - fifo_read_en=0, out_valid=0, out_is_header=0, out_last=0, out_data=0.
  - A reset in any state discards the partial or in-flight frame; nothing is emitted afterwards for it.
- FIFO side:
  - fifo_read_en is combinational from state, count and fifo_empty. The FIFO pops on the same edge, so there is no registered delay.
  - fifo_read_en is NEVER 1 while fifo_empty=1; the FIFO has no underflow guard.
  - A popped word is captured from fifo_read_data on the edge where fifo_read_en=1.
- State IDLE:
  - fifo_read_en = !fifo_empty.
  - On a pop: buf[0] <= data, count <= 1, timer <= 0, go to COLLECT. If MaxBurst=1, go to HEADER instead.
- State COLLECT:
  - fifo_read_en = !fifo_empty.
  - On a pop: buf[count] <= data, count++, timer <= 0. If count+1 == MaxBurst, go to HEADER and set flushed=0.
  - On an empty cycle: timer++. If timer == TimeoutCycles-1, go to HEADER and set flushed=1.
  - Result: the flush fires after exactly TimeoutCycles consecutive empty cycles.
- State HEADER:
  - fifo_read_en=0, out_valid=1, out_is_header=1, out_last=0.
  - out_data: bit DataWidth-1 = flushed; bits LenWidth-1:0 = count; all other bits are 0.
  - On out_valid && out_ready: index <= 0, go to PAYLOAD.
- State PAYLOAD:
  - fifo_read_en=0, out_valid=1, out_is_header=0, out_data=buf[index], out_last=(index == count-1).
  - On a handshake: index++.
  - On a handshake with out_last=1: frame_count++, go to IDLE.
  - A new burst may start popping in the cycle after returning to IDLE.
- Output stream rules:
  - out_valid, out_data, out_is_header and out_last are driven only from registers (state, buffer, index). There is no combinational path from out_ready.
  - While out_valid=1 and out_ready=0, all output fields are held stable.
  - out_valid never drops without a handshake, except on reset.
- Latency:
  - The header is valid in the cycle after the edge that pops the MaxBurst-th word.
  - With out_ready=1 throughout, a full frame occupies MaxBurst pop cycles, then 1 header cycle, then MaxBurst payload cycles.
- Arithmetic: count, index and timer are unsigned and never exceed their bounds. frame_count wraps modulo 2^16.

Test Plan:
- Reset: hold rst=1 for 2 cycles with fifo_empty=0 -> fifo_read_en=0, out_valid=0, out_data=0, frame_count=0.
- Full burst: FIFO holds 0xA0,0xA1,0xA2,0xA3 and out_ready=1 -> fifo_read_en high for 4 consecutive cycles. Output is header 0x00000004, then 0xA0..0xA3 with out_last only on 0xA3. frame_count becomes 1.
- Timeout flush: push 0x11 and 0x22, then keep the FIFO empty -> after 16 empty cycles, header 0x80000002, then 0x11, then 0x22 with out_last=1.
- Backpressure: hold out_ready=0 for 5 cycles during the header and again on payload word 2 -> out_data/flags stable, no fifo_read_en, all words delivered in order.
- Empty guard: fifo_empty=1 for 100 cycles after reset -> fifo_read_en and out_valid stay 0.
- Reset mid-frame: assert rst for 1 cycle after the 2nd payload handshake -> out_valid=0 on the next cycle, frame_count=0. A following 4-word burst 0xB0..0xB3 is framed normally with header 0x00000004.
